// File: rtl/sign_extend_pkg.sv
// -----------------------------------------------------------------------------
// sign_extend_pkg
//   Shared definitions for the immediate-extension block: the 2-bit
//   extension-mode encodings and the default immediate/datapath widths.
// -----------------------------------------------------------------------------
package sign_extend_pkg;

  // Default widths: 16-bit MIPS immediate widened onto a 32-bit datapath.
  localparam int SE_IN_W  = 16;
  localparam int SE_OUT_W = 32;

  typedef logic [1:0] ext_mode_t;

  // Extension modes for the registered path.
  localparam ext_mode_t EXT_SIGN = 2'b00;  // sign extension
  localparam ext_mode_t EXT_ZERO = 2'b01;  // zero extension
  localparam ext_mode_t EXT_LUI  = 2'b10;  // immediate in the upper bits
  localparam ext_mode_t EXT_BOFS = 2'b11;  // sign-extended word offset (<< 2)

endpackage : sign_extend_pkg

// File: rtl/sign_extend_if.sv
// -----------------------------------------------------------------------------
// sign_extend_if
//   Bundles the data/handshake signals of sign_extend.
//   master : drives value, in_valid, ext_mode; observes the results
//   slave  : the extension block itself
//   Signals:
//     value     immediate field, instr[IN_W-1:0]
//     outputval combinational sign extension of value
//     in_valid  qualifies value/ext_mode for the registered path
//     ext_mode  extension mode for the registered path
//     ext_q     registered, mode-selected result
//     out_valid ext_q holds a result captured on the previous cycle
// -----------------------------------------------------------------------------
interface sign_extend_if
  import sign_extend_pkg::*;
#(
  parameter int IN_W  = SE_IN_W,
  parameter int OUT_W = SE_OUT_W
);

  logic [IN_W-1:0]  value;
  logic [OUT_W-1:0] outputval;
  logic             in_valid;
  ext_mode_t        ext_mode;
  logic [OUT_W-1:0] ext_q;
  logic             out_valid;

  modport master (
    output value, in_valid, ext_mode,
    input  outputval, ext_q, out_valid
  );

  modport slave (
    input  value, in_valid, ext_mode,
    output outputval, ext_q, out_valid
  );

endinterface : sign_extend_if

// File: rtl/sign_extend_core.sv
// -----------------------------------------------------------------------------
// sign_extend_core
//   Combinational extension mux: widens an IN_W immediate to OUT_W bits
//   according to mode_i (sign, zero, LUI or branch offset).
//   Ports:
//     value_i  [IN_W-1:0]  immediate field
//     mode_i   [1:0]       extension mode (EXT_* from sign_extend_pkg)
//     result_o [OUT_W-1:0] extended result
// -----------------------------------------------------------------------------
module sign_extend_core
  import sign_extend_pkg::*;
#(
  parameter int IN_W  = SE_IN_W,
  parameter int OUT_W = SE_OUT_W
) (
  input  logic [IN_W-1:0]  value_i,
  input  ext_mode_t        mode_i,
  output logic [OUT_W-1:0] result_o
);

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;

  // Size casts stay legal when IN_W == OUT_W, where a zero-width
  // replication would not.
  assign sext = OUT_W'(signed'(value_i));
  assign zext = OUT_W'(value_i);

  // NOTE: result_o is assigned on every path (default first), so no latch
  // is inferred for this combinational block.
  always_comb begin
    result_o = sext;
    case (mode_i)
      EXT_SIGN: result_o = sext;
      EXT_ZERO: result_o = zext;
      EXT_LUI:  result_o = zext << (OUT_W - IN_W);
      // Bits shifted past the MSB are dropped: the offset wraps mod 2^OUT_W.
      EXT_BOFS: result_o = sext << 2;
      default:  result_o = sext;
    endcase
  end

endmodule : sign_extend_core

// File: rtl/sign_extend.sv
// -----------------------------------------------------------------------------
// sign_extend
//   Widens a MIPS instruction immediate for the ALU operand and branch/LUI
//   datapaths. Two outputs:
//     outputval : zero-latency sign extension, independent of clk/rst
//     ext_q     : mode-selected extension registered with 1-cycle latency,
//                 qualified by out_valid
//   Ports:
//     clk  single clock, rising edge
//     rst  synchronous, active-high reset
//     bus  sign_extend_if.slave (value, in_valid, ext_mode in;
//          outputval, ext_q, out_valid out)
//   IN_W must not exceed OUT_W.
// -----------------------------------------------------------------------------
module sign_extend
  import sign_extend_pkg::*;
#(
  parameter int IN_W  = SE_IN_W,
  parameter int OUT_W = SE_OUT_W
) (
  input  logic          clk,
  input  logic          rst,
  sign_extend_if.slave  bus
);

  logic [OUT_W-1:0] sext_comb;
  logic [OUT_W-1:0] ext_comb;

  logic [OUT_W-1:0] ext_d;
  logic [OUT_W-1:0] ext_q_q;
  logic             valid_d;
  logic             valid_q;

  // Combinational path: mode hard-wired to sign extension.
  sign_extend_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core_comb (
    .value_i  (bus.value),
    .mode_i   (EXT_SIGN),
    .result_o (sext_comb)
  );

  // Registered path: mode chosen per transaction.
  sign_extend_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core_reg (
    .value_i  (bus.value),
    .mode_i   (bus.ext_mode),
    .result_o (ext_comb)
  );

  // Result holds when no new input is offered; valid only pulses for the
  // cycle following an accepted input.
  always_comb begin
    ext_d   = ext_q_q;
    valid_d = 1'b0;
    if (bus.in_valid) begin
      ext_d   = ext_comb;
      valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q_q <= '0;
      valid_q <= 1'b0;
    end else begin
      ext_q_q <= ext_d;
      valid_q <= valid_d;
    end
  end

  assign bus.outputval = sext_comb;
  assign bus.ext_q     = ext_q_q;
  assign bus.out_valid = valid_q;

endmodule : sign_extend

// File: tb/tb_sign_extend.sv
// -----------------------------------------------------------------------------
// tb_sign_extend
//   Self-checking bench for sign_extend: directed boundary cases followed by
//   a randomized sweep compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_sign_extend;
  import sign_extend_pkg::*;

  logic clk;
  logic rst;
  bit   clk_run;

  int n_tests;
  int n_fail;

  sign_extend_if #(.IN_W(16), .OUT_W(32)) bus ();

  sign_extend #(.IN_W(16), .OUT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock only starts once the no-clock combinational checks are done.
  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: arithmetic on the immediate's numeric value.
  function automatic logic [31:0] ref_ext(input logic [1:0] mode,
                                          input logic [15:0] val);
    longint u;
    longint s;
    longint r;
    u = longint'(val);
    s = (u >= 32768) ? u - 65536 : u;
    case (mode)
      2'd0:    r = s;
      2'd1:    r = u;
      2'd2:    r = u * 65536;
      default: r = s * 4;
    endcase
    r = r % 64'sd4294967296;
    if (r < 0) r = r + 64'sd4294967296;
    return r[31:0];
  endfunction

  // Advance one clock and settle past the edge before sampling.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_q;
  logic        exp_v;
  logic [15:0] rv;
  logic [1:0]  rm;
  logic        ri;
  logic        rr;
  logic [15:0] corner [4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk_run = 1'b0;
    rst      = 1'b0;
    bus.in_valid = 1'b0;
    bus.ext_mode = EXT_SIGN;
    bus.value    = 16'h0000;
    corner[0] = 16'h0000; corner[1] = 16'h7FFF;
    corner[2] = 16'h8000; corner[3] = 16'hFFFF;

    // Combinational output with no clock at all.
    #1 check("comb_0", bus.outputval, 32'h00000000);
    bus.value = 16'h0001;
    #1 check("comb_1", bus.outputval, 32'h00000001);
    bus.value = 16'hFFFF;
    #1 check("comb_ffff", bus.outputval, 32'hFFFFFFFF);
    bus.value = 16'h8000;
    #1 check("comb_8000", bus.outputval, 32'hFFFF8000);
    bus.value = 16'h7FFF;
    #1 check("comb_7fff", bus.outputval, 32'h00007FFF);

    // Reset for two cycles.
    clk_run = 1'b1;
    rst = 1'b1;
    cycle();
    check("rst1_q", bus.ext_q, 32'h0);
    check("rst1_v", {31'b0, bus.out_valid}, 32'h0);
    cycle();
    check("rst2_q", bus.ext_q, 32'h0);
    check("rst2_v", {31'b0, bus.out_valid}, 32'h0);

    // First valid input after reset.
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.ext_mode = EXT_SIGN;
    bus.value    = 16'hFFFF;
    cycle();
    check("first_q", bus.ext_q, 32'hFFFFFFFF);
    check("first_v", {31'b0, bus.out_valid}, 32'h1);

    // 0x8001 through every mode, back to back.
    bus.value = 16'h8001;
    bus.ext_mode = EXT_ZERO;
    cycle();
    check("zero_8001", bus.ext_q, 32'h00008001);
    bus.ext_mode = EXT_LUI;
    cycle();
    check("lui_8001", bus.ext_q, 32'h80010000);
    bus.ext_mode = EXT_BOFS;
    cycle();
    check("bofs_8001", bus.ext_q, 32'hFFFE0004);
    bus.ext_mode = EXT_SIGN;
    cycle();
    check("sign_8001", bus.ext_q, 32'hFFFF8001);
    check("sign_8001_v", {31'b0, bus.out_valid}, 32'h1);

    // Idle: result holds, valid drops.
    bus.in_valid = 1'b0;
    bus.value    = 16'h1234;
    bus.ext_mode = EXT_ZERO;
    cycle();
    check("hold_q", bus.ext_q, 32'hFFFF8001);
    check("hold_v", {31'b0, bus.out_valid}, 32'h0);
    check("hold_comb", bus.outputval, 32'h00001234);

    // Reset overrides a valid input.
    rst = 1'b1;
    bus.in_valid = 1'b1;
    cycle();
    check("rst_ovr_q", bus.ext_q, 32'h0);
    check("rst_ovr_v", {31'b0, bus.out_valid}, 32'h0);
    rst = 1'b0;
    bus.value    = 16'h7FFF;
    bus.ext_mode = EXT_SIGN;
    cycle();
    check("post_rst_q", bus.ext_q, 32'h00007FFF);
    check("post_rst_v", {31'b0, bus.out_valid}, 32'h1);

    // Randomized sweep against the reference model.
    exp_q = 32'h00007FFF;
    exp_v = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rv = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)]
                                       : 16'($urandom);
      rm = 2'($urandom);
      ri = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 19) == 0);
      rst          = rr;
      bus.in_valid = ri;
      bus.ext_mode = rm;
      bus.value    = rv;
      #1 check("rnd_comb", bus.outputval, ref_ext(2'd0, rv));
      if (rr) begin
        exp_q = 32'h0;
        exp_v = 1'b0;
      end else if (ri) begin
        exp_q = ref_ext(rm, rv);
        exp_v = 1'b1;
      end else begin
        exp_v = 1'b0;
      end
      cycle();
      check("rnd_q", bus.ext_q, exp_q);
      check("rnd_v", {31'b0, bus.out_valid}, {31'b0, exp_v});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sign_extend
